// File: rtl/core_pkg.sv
// Shared core definitions: register-file geometry and the writeback request
// bundle used by the execute and load units.
package core_pkg;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = $clog2(NREG);
  localparam logic [AW-1:0] REG_X0 = '0;

  // Wide enough for any legal starvation limit (1..15).
  localparam int STARVE_W = 4;

  typedef struct packed {
    logic            valid;
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/wb_port_arbiter.sv
// Fixed-priority arbiter for the register-file write port: the ALU (src0) wins
// unless the load unit (src1) has lost STARVE_MAX consecutive cycles.
module wb_port_arbiter
  import core_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic s0_valid,
  input  logic s1_valid,
  output logic grant0,
  output logic grant1
);

  localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

  logic [STARVE_W-1:0] starve_cnt_q, starve_cnt_d;
  logic                force1;

  // Grants look only at valids and the counter, never at downstream state.
  always_comb begin
    force1       = s1_valid && (starve_cnt_q == STARVE_LIM);
    grant1       = !reset && s1_valid && (force1 || !s0_valid);
    grant0       = !reset && s0_valid && !force1;
    starve_cnt_d = '0;
    if (s1_valid && !grant1) begin
      starve_cnt_d = (starve_cnt_q == STARVE_LIM) ? starve_cnt_q : starve_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Owns the register-file write port: arbitrates two writeback sources, registers
// the winning write, and keeps a busy-bit scoreboard that stalls decode on hazards.
module regfile_wb_scheduler
  import core_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            s0_valid,
  input  logic [AW-1:0]   s0_rd,
  input  logic [XLEN-1:0] s0_data,
  output logic            s0_ready,
  input  logic            s1_valid,
  input  logic [AW-1:0]   s1_rd,
  input  logic [XLEN-1:0] s1_data,
  output logic            s1_ready,
  input  logic            iss_valid,
  input  logic [AW-1:0]   iss_rd,
  input  logic [AW-1:0]   iss_rs1,
  input  logic [AW-1:0]   iss_rs2,
  input  logic            iss_use_rs1,
  input  logic            iss_use_rs2,
  output logic            hz_stall,
  output logic            wb_wen,
  output logic [AW-1:0]   wb_sel,
  output logic [XLEN-1:0] wb_data,
  output logic [NREG-1:0] busy
);

  // Handshake: a source transfers when valid && ready in the same cycle; once
  // valid is raised it holds valid, rd and data stable until ready is seen.

  wb_req_t         s0_req, s1_req, win_req;
  logic            grant0, grant1, granted, issue_fire;
  logic            wb_wen_q, wb_wen_d;
  logic [AW-1:0]   wb_sel_q, wb_sel_d;
  logic [XLEN-1:0] wb_data_q, wb_data_d;
  logic [NREG-1:0] busy_q, busy_d;

  wb_port_arbiter #(.STARVE_MAX(STARVE_MAX)) u_arb (
    .clock    (clock),
    .reset    (reset),
    .s0_valid (s0_valid),
    .s1_valid (s1_valid),
    .grant0   (grant0),
    .grant1   (grant1)
  );

  always_comb begin
    s0_req  = '{valid: s0_valid, rd: s0_rd, data: s0_data};
    s1_req  = '{valid: s1_valid, rd: s1_rd, data: s1_data};
    win_req = grant0 ? s0_req : s1_req;
    granted = (grant0 || grant1) && win_req.valid;

    hz_stall = !reset && iss_valid &&
               ((iss_use_rs1 && busy_q[iss_rs1]) ||
                (iss_use_rs2 && busy_q[iss_rs2]) ||
                busy_q[iss_rd]);
    issue_fire = iss_valid && !hz_stall && (iss_rd != REG_X0);

    // x0 writes are accepted but never reach the register file.
    wb_wen_d  = granted && (win_req.rd != REG_X0);
    wb_sel_d  = granted ? win_req.rd   : wb_sel_q;
    wb_data_d = granted ? win_req.data : wb_data_q;

    // Clear first so a same-cycle issue to the same register keeps it busy.
    busy_d = busy_q;
    if (wb_wen_q) begin
      busy_d[wb_sel_q] = 1'b0;
    end
    if (issue_fire) begin
      busy_d[iss_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wb_wen_q  <= 1'b0;
      wb_sel_q  <= '0;
      wb_data_q <= '0;
      busy_q    <= '0;
    end else begin
      wb_wen_q  <= wb_wen_d;
      wb_sel_q  <= wb_sel_d;
      wb_data_q <= wb_data_d;
      busy_q    <= busy_d;
    end
  end

  // Reset masks the registered write immediately so an in-flight write is dropped.
  assign s0_ready = grant0;
  assign s1_ready = grant1;
  assign wb_wen   = wb_wen_q && !reset;
  assign wb_sel   = reset ? '0 : wb_sel_q;
  assign wb_data  = reset ? '0 : wb_data_q;
  assign busy     = reset ? '0 : busy_q;

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Directed scenarios plus randomized traffic for regfile_wb_scheduler, checked
// against a behavioural model of arbitration, writeback and the scoreboard.
module tb_regfile_wb_scheduler;
  import core_pkg::*;

  localparam int STARVE_MAX = 4;

  logic            clock = 1'b0;
  logic            reset;
  logic            s0_valid, s1_valid, s0_ready, s1_ready;
  logic [AW-1:0]   s0_rd, s1_rd;
  logic [XLEN-1:0] s0_data, s1_data;
  logic            iss_valid, iss_use_rs1, iss_use_rs2, hz_stall;
  logic [AW-1:0]   iss_rd, iss_rs1, iss_rs2;
  logic            wb_wen;
  logic [AW-1:0]   wb_sel;
  logic [XLEN-1:0] wb_data;
  logic [NREG-1:0] busy;

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  regfile_wb_scheduler #(.STARVE_MAX(STARVE_MAX)) dut (
    .clock(clock), .reset(reset),
    .s0_valid(s0_valid), .s0_rd(s0_rd), .s0_data(s0_data), .s0_ready(s0_ready),
    .s1_valid(s1_valid), .s1_rd(s1_rd), .s1_data(s1_data), .s1_ready(s1_ready),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_rs1(iss_rs1), .iss_rs2(iss_rs2),
    .iss_use_rs1(iss_use_rs1), .iss_use_rs2(iss_use_rs2), .hz_stall(hz_stall),
    .wb_wen(wb_wen), .wb_sel(wb_sel), .wb_data(wb_data), .busy(busy)
  );

  // ---------------- scoreboard / reference model ----------------
  int n_tests = 0;
  int n_fail  = 0;
  int n_idle_wb = 0;

  bit [NREG-1:0]   m_busy;     // registers with an outstanding writer
  int              m_lost;     // consecutive cycles src1 waited without a grant
  logic [AW-1:0]   m_sel;
  logic [XLEN-1:0] m_data;
  logic [AW+XLEN-1:0] exp_q[$]; // writes the register file must still see: {rd, data}
  bit e_g0, e_g1, e_stall;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic model_comb();
    bit starved;
    if (reset) begin
      e_g0 = 0; e_g1 = 0; e_stall = 0;
    end else begin
      starved = s1_valid && (m_lost == STARVE_MAX);
      e_g1    = s1_valid && (starved || !s0_valid);
      e_g0    = s0_valid && !starved;
      e_stall = iss_valid && ((iss_use_rs1 && m_busy[iss_rs1]) ||
                              (iss_use_rs2 && m_busy[iss_rs2]) || m_busy[iss_rd]);
    end
  endtask

  task automatic check_outputs();
    logic [AW+XLEN-1:0] e;
    bit exp_wen;
    model_comb();
    exp_wen = !reset && (exp_q.size() > 0);
    check("s0_ready", 32'(s0_ready), 32'(e_g0));
    check("s1_ready", 32'(s1_ready), 32'(e_g1));
    check("hz_stall", 32'(hz_stall), 32'(e_stall));
    check("busy", busy, reset ? '0 : m_busy);
    check("wb_wen", 32'(wb_wen), 32'(exp_wen));
    check("wb_sel", 32'(wb_sel), reset ? '0 : 32'(m_sel));
    check("wb_data", wb_data, reset ? '0 : m_data);
    if (exp_wen && wb_wen) begin
      e = exp_q[0];
      check("rf_write_rd", 32'(wb_sel), 32'(e[AW+XLEN-1:XLEN]));
      check("rf_write_data", wb_data, e[XLEN-1:0]);
    end
  endtask

  task automatic model_update();
    logic [AW+XLEN-1:0] e;
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] dat;
    if (reset) begin
      m_busy = '0; m_lost = 0; m_sel = '0; m_data = '0;
      exp_q.delete();
      return;
    end
    if (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      rd = e[AW+XLEN-1:XLEN];
      if (!m_busy[rd]) begin
        n_idle_wb++;
        $display("[TB] note: writeback to idle register x%0d at %0t", rd, $time);
      end
      m_busy[rd] = 1'b0;
    end
    if (iss_valid && !e_stall && iss_rd != 0) m_busy[iss_rd] = 1'b1;
    if (e_g0 || e_g1) begin
      rd  = e_g0 ? s0_rd : s1_rd;
      dat = e_g0 ? s0_data : s1_data;
      m_sel  = rd;
      m_data = dat;
      if (rd != 0) exp_q.push_back({rd, dat});
    end
    if (s1_valid && !e_g1) m_lost = (m_lost < STARVE_MAX) ? m_lost + 1 : m_lost;
    else m_lost = 0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic sample();
    @(negedge clock);
    check_outputs();
  endtask

  task automatic advance();
    @(posedge clock);
    model_update();
    #1;
  endtask

  task automatic step();
    sample();
    advance();
  endtask

  task automatic idle_inputs();
    s0_valid = 0; s1_valid = 0; iss_valid = 0;
    iss_use_rs1 = 0; iss_use_rs2 = 0;
    iss_rd = '0; iss_rs1 = '0; iss_rs2 = '0;
  endtask

  function automatic logic [AW-1:0] pick_rd();
    int start;
    if ($urandom_range(0, 3) == 0) return AW'($urandom_range(0, NREG - 1));
    start = $urandom_range(1, NREG - 1);
    for (int k = 0; k < NREG; k++) begin
      if (m_busy[(start + k) % NREG]) return AW'((start + k) % NREG);
    end
    return AW'($urandom_range(1, NREG - 1));
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    reset = 1; idle_inputs();
    s0_rd = '0; s1_rd = '0; s0_data = '0; s1_data = '0;
    m_busy = '0; m_lost = 0; m_sel = '0; m_data = '0;

    // T1: reset held two cycles with a pending ALU request
    s0_valid = 1; s0_rd = 5'd1; s0_data = 32'h1111_0001;
    for (int i = 0; i < 2; i++) begin
      sample();
      check("t1_ready0_in_reset", 32'(s0_ready), 32'd0);
      check("t1_wen_in_reset", 32'(wb_wen), 32'd0);
      check("t1_busy_in_reset", busy, 32'd0);
      advance();
    end
    reset = 0;
    sample();
    check("t1_first_grant", 32'(s0_ready), 32'd1);
    advance();
    s0_valid = 0;
    step();

    // T2: sustained contention, src1 forced every STARVE_MAX+1 cycles
    s0_valid = 1; s0_rd = 5'd3; s0_data = 32'hA0A0_0003;
    s1_valid = 1; s1_rd = 5'd4; s1_data = 32'hB1B1_0004;
    for (int i = 0; i < 10; i++) begin
      sample();
      check("t2_grant0", 32'(s0_ready), (i == 4 || i == 9) ? 32'd0 : 32'd1);
      check("t2_grant1", 32'(s1_ready), (i == 4 || i == 9) ? 32'd1 : 32'd0);
      advance();
    end
    idle_inputs();
    step();

    // T3: write to x0 is accepted but dropped
    s0_valid = 1; s0_rd = 5'd0; s0_data = 32'hDEAD_BEEF;
    sample();
    check("t3_ready0", 32'(s0_ready), 32'd1);
    advance();
    s0_valid = 0;
    sample();
    check("t3_wen", 32'(wb_wen), 32'd0);
    check("t3_busy", busy, 32'd0);
    advance();

    // T4: RAW hazard on x5 until the cycle after its writeback
    iss_valid = 1; iss_rd = 5'd5;
    step();
    iss_rd = 5'd0; iss_rs1 = 5'd5; iss_use_rs1 = 1;
    s0_valid = 1; s0_rd = 5'd5; s0_data = $urandom;
    sample();
    check("t4_busy5", 32'(busy[5]), 32'd1);
    check("t4_stall_pending", 32'(hz_stall), 32'd1);
    advance();
    s0_valid = 0;
    sample();
    check("t4_wen", 32'(wb_wen), 32'd1);
    check("t4_sel", 32'(wb_sel), 32'd5);
    check("t4_stall_wb_cycle", 32'(hz_stall), 32'd1);
    advance();
    sample();
    check("t4_stall_released", 32'(hz_stall), 32'd0);
    advance();
    idle_inputs();

    // T5: clear and set of x7 on the same edge leaves it busy
    s0_valid = 1; s0_rd = 5'd7; s0_data = 32'h0000_0777;
    step();
    s0_valid = 0; iss_valid = 1; iss_rd = 5'd7;
    sample();
    check("t5_wen", 32'(wb_wen), 32'd1);
    check("t5_sel", 32'(wb_sel), 32'd7);
    check("t5_no_stall", 32'(hz_stall), 32'd0);
    advance();
    iss_valid = 0;
    sample();
    check("t5_busy7", 32'(busy[7]), 32'd1);
    advance();

    // T6: WAW stall on x9, then reset right after the grant
    iss_valid = 1; iss_rd = 5'd9;
    step();
    sample();
    check("t6_waw_stall", 32'(hz_stall), 32'd1);
    advance();
    iss_valid = 0; s0_valid = 1; s0_rd = 5'd9; s0_data = 32'h9999_0009;
    sample();
    check("t6_grant", 32'(s0_ready), 32'd1);
    advance();
    s0_valid = 0; reset = 1;
    sample();
    check("t6_wen_suppressed", 32'(wb_wen), 32'd0);
    check("t6_busy_cleared", busy, 32'd0);
    advance();
    reset = 0;
    sample();
    check("t6_busy_after", busy, 32'd0);
    advance();

    // Randomized traffic with legal valid/ready holding
    idle_inputs();
    for (int c = 0; c < 800; c++) begin
      if (!s0_valid || e_g0) begin
        s0_valid = ($urandom_range(0, 99) < 60);
        s0_rd    = pick_rd();
        s0_data  = $urandom;
      end
      if (!s1_valid || e_g1) begin
        s1_valid = ($urandom_range(0, 99) < 45);
        s1_rd    = pick_rd();
        s1_data  = $urandom;
      end
      iss_valid   = ($urandom_range(0, 1) == 1);
      iss_rd      = AW'($urandom_range(0, NREG - 1));
      iss_rs1     = AW'($urandom_range(0, NREG - 1));
      iss_rs2     = AW'($urandom_range(0, NREG - 1));
      iss_use_rs1 = ($urandom_range(0, 1) == 1);
      iss_use_rs2 = ($urandom_range(0, 1) == 1);
      reset       = ($urandom_range(0, 99) == 0);
      step();
    end
    reset = 0; idle_inputs();
    step();

    // ---------------- final report ----------------
    $display("[TB] writebacks to idle registers: %0d", n_idle_wb);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
